// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver into the FIFO, pop/status toward the core.
// UART_RX_FIFO_TIMEOUT_EN adds s_tick and rx_timeout.
interface uart_rx_fifo_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              rx_done_tick;
    logic [DBIT-1:0]   rx_dout;
    logic              rd;
    logic              clr_overrun;
    logic [DBIT-1:0]   r_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic              s_tick;
    logic              rx_timeout;

    modport master (
        output rx_done_tick, rx_dout, rd, clr_overrun, s_tick,
        input  r_data, empty, full, count, overrun, rx_timeout
    );
    modport slave (
        input  rx_done_tick, rx_dout, rd, clr_overrun, s_tick,
        output r_data, empty, full, count, overrun, rx_timeout
    );
`else
    modport master (
        output rx_done_tick, rx_dout, rd, clr_overrun,
        input  r_data, empty, full, count, overrun
    );
    modport slave (
        input  rx_done_tick, rx_dout, rd, clr_overrun,
        output r_data, empty, full, count, overrun
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular FWFT receive FIFO behind the UART receiver with sticky overrun.
// Define UART_RX_FIFO_TIMEOUT_EN for the s_tick-based idle timeout.
module uart_rx_fifo #(
    parameter int DBIT          = 8,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovr;
    logic              is_empty;
    logic              is_full;
    logic              push;
    logic              pop;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // A full FIFO still accepts a byte when the consumer pops in the same cycle.
    assign push = bus.rx_done_tick & (~is_full | bus.rd);
    assign pop  = bus.rd & ~is_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= bus.rx_dout;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Setting beats clearing so a drop in the clear cycle is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (bus.rx_done_tick & is_full & ~bus.rd) begin
            ovr <= 1'b1;
        end else if (bus.clr_overrun) begin
            ovr <= 1'b0;
        end
    end

    assign bus.r_data  = mem[rd_ptr];
    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.count   = cnt;
    assign bus.overrun = ovr;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IW-1:0] TT = IW'(TIMEOUT_TICKS);

    logic [IW-1:0] idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle <= '0;
        end else if (push | pop | is_empty) begin
            idle <= '0;
        end else if (bus.s_tick && idle != TT) begin
            idle <= idle + 1'b1;
        end
    end

    assign bus.rx_timeout = (idle == TT) & ~is_empty;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DBIT   = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TT     = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_rx_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(
        .DBIT(DBIT), .ADDR_W(ADDR_W), .TIMEOUT_TICKS(TT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of bytes plus the sticky flag.
    logic [7:0] q[$];
    bit         m_ovr;
    int         m_idle;
    bit         s_tick_v;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit done, input logic [7:0] din,
                              input bit rd_i, input bit clr, input bit rst);
        bit f, e, ps, pp;
        if (rst) begin
            q.delete();
            m_ovr  = 0;
            m_idle = 0;
            return;
        end
        f  = (q.size() == DEPTH);
        e  = (q.size() == 0);
        pp = rd_i && !e;
        ps = done && (!f || rd_i);
        if (done && f && !rd_i) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (ps || pp || e) m_idle = 0;
        else if (s_tick_v && m_idle < TT) m_idle++;
        if (pp) void'(q.pop_front());
        if (ps) q.push_back(din);
    endtask

    task automatic cmp_model();
        chk("count", int'(bus.count), q.size());
        chk("empty", int'(bus.empty), int'(q.size() == 0));
        chk("full", int'(bus.full), int'(q.size() == DEPTH));
        chk("overrun", int'(bus.overrun), int'(m_ovr));
        if (q.size() > 0) chk("r_data", int'(bus.r_data), int'(q[0]));
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("rx_timeout", int'(bus.rx_timeout),
            int'(m_idle == TT && q.size() > 0));
`endif
    endtask

    task automatic cycle(input bit done, input logic [7:0] din,
                         input bit rd_i, input bit clr, input bit rst);
        bus.rx_done_tick = done;
        bus.rx_dout      = din;
        bus.rd           = rd_i;
        bus.clr_overrun  = clr;
        reset            = rst;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        bus.s_tick       = s_tick_v;
`endif
        @(posedge clk);
        #1;
        model_step(done, din, rd_i, clr, rst);
        cmp_model();
    endtask

    typedef struct {
        bit         done;
        logic [7:0] din;
        bit         rd;
        int         e_count;
        bit         e_empty;
        bit         chk_head;
        logic [7:0] e_head;
    } vec_t;

    vec_t vt[$];

    initial begin
        s_tick_v = 0;
        vt = '{
            '{1, 8'h41, 0, 1, 0, 1, 8'h41},
            '{1, 8'h42, 0, 2, 0, 1, 8'h41},
            '{1, 8'h43, 0, 3, 0, 1, 8'h41},
            '{0, 8'h00, 1, 2, 0, 1, 8'h42},
            '{0, 8'h00, 1, 1, 0, 1, 8'h43},
            '{0, 8'h00, 1, 0, 1, 0, 8'h00},
            '{0, 8'h00, 1, 0, 1, 0, 8'h00},
            '{1, 8'h7E, 1, 1, 0, 1, 8'h7E},
            '{0, 8'h00, 1, 0, 1, 0, 8'h00}
        };

        cycle(1, 8'h99, 0, 0, 1);
        chk("reset_count", int'(bus.count), 0);
        chk("reset_empty", int'(bus.empty), 1);
        chk("reset_full", int'(bus.full), 0);
        chk("reset_ovr", int'(bus.overrun), 0);
        chk("reset_rdata", int'(bus.r_data), 0);

        foreach (vt[i]) begin
            cycle(vt[i].done, vt[i].din, vt[i].rd, 0, 0);
            chk($sformatf("vec%0d_count", i), int'(bus.count), vt[i].e_count);
            chk($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vt[i].e_empty));
            if (vt[i].chk_head)
                chk($sformatf("vec%0d_head", i), int'(bus.r_data), int'(vt[i].e_head));
        end

        // Fill, overrun with 0xAA, drain without ever seeing it.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 16);
        cycle(1, 8'hAA, 0, 0, 0);
        chk("ovr_set", int'(bus.overrun), 1);
        chk("ovr_count", int'(bus.count), 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), int'(bus.r_data), i);
            cycle(0, 8'h00, 1, 0, 0);
        end
        chk("drain_empty", int'(bus.empty), 1);

        // Push+pop while full keeps count at 16 and never overruns.
        cycle(0, 8'h00, 0, 1, 0);
        chk("clr_lone", int'(bus.overrun), 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0);
        cycle(1, 8'h55, 1, 0, 0);
        chk("pp_full_count", int'(bus.count), 16);
        chk("pp_full_ovr", int'(bus.overrun), 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 8'h00, 1, 0, 0);
        chk("pp_full_tail", int'(bus.r_data), 8'h55);

        // Refill, overrun, then clear coinciding with a new overrun.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1, 8'(i), 0, 0, 0);
        cycle(1, 8'hAB, 0, 0, 0);
        chk("ovr2_set", int'(bus.overrun), 1);
        cycle(1, 8'hAC, 0, 1, 0);
        chk("ovr_set_wins", int'(bus.overrun), 1);
        cycle(0, 8'h00, 0, 1, 0);
        chk("ovr_cleared", int'(bus.overrun), 0);

        // Mid-stream reset at count 5 with overrun set.
        cycle(1, 8'hAD, 0, 0, 0);
        for (int i = 0; i < DEPTH - 5; i++) cycle(0, 8'h00, 1, 0, 0);
        chk("pre_rst_count", int'(bus.count), 5);
        cycle(1, 8'hEE, 0, 0, 1);
        chk("rst_mid_count", int'(bus.count), 0);
        chk("rst_mid_empty", int'(bus.empty), 1);
        chk("rst_mid_ovr", int'(bus.overrun), 0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
        cycle(1, 8'h31, 0, 0, 0);
        s_tick_v = 1;
        for (int i = 0; i < TT - 1; i++) cycle(0, 8'h00, 0, 0, 0);
        chk("to_early", int'(bus.rx_timeout), 0);
        cycle(0, 8'h00, 0, 0, 0);
        chk("to_set", int'(bus.rx_timeout), 1);
        s_tick_v = 0;
        cycle(0, 8'h00, 1, 0, 0);
        chk("to_clear", int'(bus.rx_timeout), 0);
`endif

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 6; ph++) begin
            int rdp = (ph % 2) ? 75 : 25;
            for (int n = 0; n < 400; n++) begin
                s_tick_v = ($urandom_range(0, 99) < 60);
                cycle($urandom_range(0, 99) < 55, 8'($urandom),
                      $urandom_range(0, 99) < rdp,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 999) < 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
